// File: rtl/audio_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_i2s_tx : one-entry buffered mono-to-stereo I2S transmitter      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module audio_i2s_tx #(
   parameter int DIV = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_valid,
   input  logic [15:0] i_data,
   output logic        o_ready,
   input  logic        i_clr_flags,
   output logic        o_bclk,
   output logic        o_lrck,
   output logic        o_dat,
   output logic        o_overflow,
   output logic        o_underrun
);

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   logic [7:0]  div_cnt;
   logic        bclk;
   logic [4:0]  slot;
   logic        lrck;
   logic        dat;
   logic [15:0] frame;
   logic [15:0] buf_data;
   logic        buf_full;
   logic        overflow;
   logic        underrun;

   logic        div_wrap;
   logic        fall_tick;
   logic [4:0]  slot_nxt;
   logic        load;
   logic        accept;
   logic [15:0] frame_nxt;
   logic [3:0]  bit_sel;
   logic        dat_nxt;

   always_comb begin
      div_wrap  = (div_cnt == DIV_LAST);
      fall_tick = i_enable & div_wrap & bclk;
      slot_nxt  = slot + 5'd1;
      load      = fall_tick & (slot_nxt == 5'd1);
      accept    = i_valid & ~buf_full;
      // On the slot-1 entry the first data bit comes from the freshly loaded word
      frame_nxt = (load && buf_full) ? buf_data : frame;
      bit_sel   = ~(slot_nxt[3:0] - 4'd1);
      dat_nxt   = frame_nxt[bit_sel];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_cnt  <= '0;
         bclk     <= 1'b0;
         slot     <= '0;
         lrck     <= 1'b0;
         dat      <= 1'b0;
         frame    <= '0;
         buf_data <= '0;
         buf_full <= 1'b0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (!i_enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= '0;
            lrck    <= 1'b0;
            dat     <= 1'b0;
         end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap) begin
               bclk <= ~bclk;
            end
            if (fall_tick) begin
               slot  <= slot_nxt;
               lrck  <= slot_nxt[4];
               dat   <= dat_nxt;
               frame <= frame_nxt;
            end
         end

         // Load and accept are mutually exclusive: accept needs an empty buffer
         if (load && buf_full) begin
            buf_full <= 1'b0;
         end
         if (accept) begin
            buf_data <= i_data;
            buf_full <= 1'b1;
         end

         if (i_valid && buf_full) begin
            overflow <= 1'b1;
         end else if (i_clr_flags) begin
            overflow <= 1'b0;
         end

         if (load && !buf_full) begin
            underrun <= 1'b1;
         end else if (i_clr_flags) begin
            underrun <= 1'b0;
         end
      end
   end

   assign o_ready    = ~buf_full;
   assign o_bclk     = bclk;
   assign o_lrck     = lrck;
   assign o_dat      = dat;
   assign o_overflow = overflow;
   assign o_underrun = underrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// Directed bench for audio_i2s_tx (DIV=2): expected slot bits are queued per
// bit-clock fall and compared as the serializer produces them.
module tb_audio_i2s_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        valid;
   logic [15:0] data;
   logic        clr_flags;
   logic        ready;
   logic        bclk;
   logic        lrck;
   logic        dat;
   logic        overflow;
   logic        underrun;

   int checks   = 0;
   int failures = 0;
   int falls    = 0;
   logic prev_bclk = 1'b0;

   typedef struct {
      int   idx;
      logic lrck;
      logic dat;
   } exp_t;
   exp_t exp_q[$];

   audio_i2s_tx #(.DIV(2)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_enable    (enable),
      .i_valid     (valid),
      .i_data      (data),
      .o_ready     (ready),
      .i_clr_flags (clr_flags),
      .o_bclk      (bclk),
      .o_lrck      (lrck),
      .o_dat       (dat),
      .o_overflow  (overflow),
      .o_underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame of a sample: slots 1..31 then slot 0, both words carry it.
   task automatic push_frame(input logic [15:0] s, input int first);
      for (int k = 1; k <= 32; k++) begin
         exp_t e;
         logic [4:0] sl;
         sl     = 5'(k % 32);
         e.idx  = first + k - 1;
         e.lrck = sl[4];
         e.dat  = s[15 - ((k - 1) % 16)];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_falls(input int target);
      int n = 0;
      while (falls < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("wait_falls", (falls >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   // Count only genuine bit-clock falls, not those forced by reset or disable.
   always @(posedge clk) begin
      #1;
      if (!rst && enable && prev_bclk && !bclk) begin
         falls++;
         if (exp_q.size() > 0 && exp_q[0].idx == falls) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("lrck_fall%0d", falls), lrck, e.lrck);
            check($sformatf("dat_fall%0d", falls), dat, e.dat);
         end
      end
      prev_bclk = bclk;
   end

   initial begin
      int f0;
      rst = 1'b1; enable = 1'b1; valid = 1'b0; data = '0; clr_flags = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bclk", bclk, 0);
      check("rst_lrck", lrck, 0);
      check("rst_dat", dat, 0);
      check("rst_ready", ready, 1);
      check("rst_ovf", overflow, 0);
      check("rst_udr", underrun, 0);

      // A5C3 then starve the buffer
      rst = 1'b0; valid = 1'b1; data = 16'hA5C3; f0 = falls;
      push_frame(16'hA5C3, f0 + 1);
      push_frame(16'hA5C3, f0 + 33);
      @(negedge clk); valid = 1'b0;
      check("s1_ready_full", ready, 0);
      check("s1_bclk_c1", bclk, 0);
      @(negedge clk); check("s1_bclk_c2", bclk, 1);
      @(negedge clk); check("s1_bclk_c3", bclk, 1);
      @(negedge clk); check("s1_bclk_c4", bclk, 0);
      check("s1_first_fall", falls, f0 + 1);
      wait_falls(f0 + 32);
      check("s1_udr_before", underrun, 0);
      check("s1_ready_after_load", ready, 1);
      wait_falls(f0 + 33);
      check("s1_udr_after", underrun, 1);
      wait_drain();

      // Back-to-back writes: second one is dropped
      do_reset();
      rst = 1'b0; valid = 1'b1; data = 16'h7FFF; f0 = falls;
      push_frame(16'h7FFF, f0 + 1);
      push_frame(16'h7FFF, f0 + 33);
      @(negedge clk); data = 16'h8000;
      check("s2_ready_second", ready, 0);
      @(negedge clk); valid = 1'b0;
      check("s2_ovf", overflow, 1);
      wait_drain();
      check("s2_udr", underrun, 1);

      // Refill each frame
      do_reset();
      rst = 1'b0; valid = 1'b1; data = 16'h0001; f0 = falls;
      push_frame(16'h0001, f0 + 1);
      @(negedge clk); valid = 1'b0;
      wait_falls(f0 + 1);
      check("s3_ready_free1", ready, 1);
      valid = 1'b1; data = 16'hFFFF; push_frame(16'hFFFF, f0 + 33);
      @(negedge clk); valid = 1'b0;
      check("s3_ready_busy", ready, 0);
      wait_falls(f0 + 32);
      check("s3_ready_held", ready, 0);
      wait_falls(f0 + 33);
      check("s3_ready_free2", ready, 1);
      valid = 1'b1; data = 16'h0001; push_frame(16'h0001, f0 + 65);
      @(negedge clk); valid = 1'b0;
      wait_drain();
      check("s3_ovf", overflow, 0);
      check("s3_udr", underrun, 0);

      // Enable drop mid-word
      do_reset();
      rst = 1'b0; valid = 1'b1; data = 16'h3C5A; f0 = falls;
      push_frame(16'h3C5A, f0 + 1);
      @(negedge clk); valid = 1'b0;
      wait_falls(f0 + 1);
      valid = 1'b1; data = 16'h6E91;
      @(negedge clk); valid = 1'b0;
      wait_falls(f0 + 8);
      enable = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("s4_pins_parked", {bclk, lrck, dat}, 0);
      end
      check("s4_buffer_kept", ready, 0);
      enable = 1'b1; f0 = falls;
      push_frame(16'h6E91, f0 + 1);
      repeat (3) @(negedge clk);
      check("s4_no_early_fall", falls, f0);
      @(negedge clk);
      check("s4_first_fall", falls, f0 + 1);
      check("s4_loaded", ready, 1);
      wait_drain();

      // Clear racing an overflow
      wait_falls(f0 + 34);
      valid = 1'b1; data = 16'h1111;
      @(negedge clk); data = 16'h2222; clr_flags = 1'b1;
      @(negedge clk); valid = 1'b0;
      check("s5_ovf_set_wins", overflow, 1);
      @(negedge clk); clr_flags = 1'b0;
      check("s5_ovf_cleared", overflow, 0);
      check("s5_udr_cleared", underrun, 0);

      // Reset during slot 9
      do_reset();
      rst = 1'b0; valid = 1'b1; data = 16'hBEEF; f0 = falls;
      push_frame(16'hBEEF, f0 + 1);
      @(negedge clk); valid = 1'b0;
      wait_falls(f0 + 1);
      valid = 1'b1; data = 16'h4321;
      @(negedge clk); valid = 1'b0;
      wait_falls(f0 + 9);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("s6_pins_zero", {bclk, lrck, dat}, 0);
      check("s6_ready", ready, 1);
      check("s6_flags", {overflow, underrun}, 0);
      rst = 1'b0; f0 = falls;
      push_frame(16'h0000, f0 + 1);
      wait_falls(f0 + 1);
      check("s6_udr", underrun, 1);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
